traffic_lamp_monitor: RTL and testbench

TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

---
 rtl/traffic_lamp_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_traffic_lamp_monitor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor between a two-direction traffic controller and its lamps:
// passes legal codes through to one-hot lamp drive, latches the first fault and flashes red.
module traffic_lamp_monitor #(
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned MAX_HOLD   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  input  logic       fault_clr,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [1:0] C_GREEN  = 2'b00;
  localparam logic [1:0] C_YELLOW = 2'b01;
  localparam logic [1:0] C_RED    = 2'b10;
  localparam logic [1:0] C_ILL    = 2'b11;

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_ILLEGAL  = 3'd1;
  localparam logic [2:0] F_CONFLICT = 3'd2;
  localparam logic [2:0] F_SEQ      = 3'd3;
  localparam logic [2:0] F_YSHORT   = 3'd4;
  localparam logic [2:0] F_WDOG     = 3'd5;

  localparam logic [2:0]  LAMP_RED   = 3'b100;
  localparam logic [2:0]  LAMP_DARK  = 3'b000;
  localparam logic [7:0]  MIN_Y8     = 8'(MIN_YELLOW);
  localparam logic [15:0] FLASH_LAST = 16'(FLASH_HALF - 1);
  localparam logic [15:0] HOLD_LIM   = 16'(MAX_HOLD);

  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      C_GREEN:  decode = 3'b001;
      C_YELLOW: decode = 3'b010;
      C_RED:    decode = 3'b100;
      default:  decode = 3'b000;
    endcase
  endfunction

  function automatic logic seq_ok(input logic [1:0] prev, input logic [1:0] cur);
    case (prev)
      C_GREEN:  seq_ok = (cur == C_GREEN)  || (cur == C_YELLOW);
      C_YELLOW: seq_ok = (cur == C_YELLOW) || (cur == C_RED);
      C_RED:    seq_ok = (cur == C_RED)    || (cur == C_GREEN);
      default:  seq_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] yel_next(input logic [7:0] cnt, input logic [1:0] cur);
    if (cur != C_YELLOW)   yel_next = 8'd0;
    else if (cnt == 8'hFF) yel_next = cnt;
    else                   yel_next = cnt + 8'd1;
  endfunction

  logic [1:0]  state, state_nx;
  logic [2:0]  lamp_a_nx, lamp_b_nx;
  logic        fault_nx;
  logic [2:0]  fault_code_nx;
  logic [1:0]  prev_a, prev_b, prev_a_nx, prev_b_nx;
  logic [7:0]  ycnt_a, ycnt_b, ycnt_a_nx, ycnt_b_nx;
  logic [15:0] hold_cnt, hold_cnt_nx;
  logic [15:0] flash_cnt, flash_cnt_nx;

  // Fault detectors, evaluated on the current sample against the previous one
  logic        illegal, conflict, seq_bad, yshort, wdog;
  logic [15:0] hold_inc;
  logic [2:0]  arm_code, run_code;

  always_comb begin
    illegal  = (La == C_ILL) || (Lb == C_ILL);
    conflict = (La != C_RED) && (Lb != C_RED);
    seq_bad  = !seq_ok(prev_a, La) || !seq_ok(prev_b, Lb);
    yshort   = ((prev_a == C_YELLOW) && (La == C_RED) && (ycnt_a < MIN_Y8)) ||
               ((prev_b == C_YELLOW) && (Lb == C_RED) && (ycnt_b < MIN_Y8));
    if ({La, Lb} != {prev_a, prev_b}) hold_inc = 16'd0;
    else if (hold_cnt == 16'hFFFF)    hold_inc = hold_cnt;
    else                              hold_inc = hold_cnt + 16'd1;
    wdog = (HOLD_LIM != 16'd0) && (hold_inc >= HOLD_LIM);

    if (illegal)       arm_code = F_ILLEGAL;
    else if (conflict) arm_code = F_CONFLICT;
    else               arm_code = F_NONE;

    if (arm_code != F_NONE) run_code = arm_code;
    else if (seq_bad)       run_code = F_SEQ;
    else if (yshort)        run_code = F_YSHORT;
    else if (wdog)          run_code = F_WDOG;
    else                    run_code = F_NONE;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx      = state;
    lamp_a_nx     = lamp_a;
    lamp_b_nx     = lamp_b;
    fault_nx      = fault;
    fault_code_nx = fault_code;
    prev_a_nx     = prev_a;
    prev_b_nx     = prev_b;
    ycnt_a_nx     = ycnt_a;
    ycnt_b_nx     = ycnt_b;
    hold_cnt_nx   = hold_cnt;
    flash_cnt_nx  = flash_cnt;

    case (state)
      ST_ARM: begin
        lamp_a_nx = LAMP_RED;
        lamp_b_nx = LAMP_RED;
        if (arm_code != F_NONE) begin
          state_nx      = ST_FAULT;
          fault_nx      = 1'b1;
          fault_code_nx = arm_code;
          flash_cnt_nx  = 16'd0;
        end else begin
          state_nx    = ST_RUN;
          lamp_a_nx   = decode(La);
          lamp_b_nx   = decode(Lb);
          prev_a_nx   = La;
          prev_b_nx   = Lb;
          hold_cnt_nx = 16'd0;
          ycnt_a_nx   = (La == C_YELLOW) ? MIN_Y8 : 8'd0;
          ycnt_b_nx   = (Lb == C_YELLOW) ? MIN_Y8 : 8'd0;
        end
      end
      ST_RUN: begin
        prev_a_nx = La;
        prev_b_nx = Lb;
        if (run_code != F_NONE) begin
          state_nx      = ST_FAULT;
          fault_nx      = 1'b1;
          fault_code_nx = run_code;
          lamp_a_nx     = LAMP_RED;
          lamp_b_nx     = LAMP_RED;
          flash_cnt_nx  = 16'd0;
        end else begin
          lamp_a_nx   = decode(La);
          lamp_b_nx   = decode(Lb);
          ycnt_a_nx   = yel_next(ycnt_a, La);
          ycnt_b_nx   = yel_next(ycnt_b, Lb);
          hold_cnt_nx = hold_inc;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_nx      = ST_ARM;
          fault_nx      = 1'b0;
          fault_code_nx = F_NONE;
          lamp_a_nx     = LAMP_RED;
          lamp_b_nx     = LAMP_RED;
        end else if (flash_cnt == FLASH_LAST) begin
          // Lamp A doubles as the flash phase; B always mirrors it
          flash_cnt_nx = 16'd0;
          lamp_a_nx    = (lamp_a == LAMP_RED) ? LAMP_DARK : LAMP_RED;
          lamp_b_nx    = (lamp_a == LAMP_RED) ? LAMP_DARK : LAMP_RED;
        end else begin
          flash_cnt_nx = flash_cnt + 16'd1;
        end
      end
      default: begin
        state_nx  = ST_ARM;
        lamp_a_nx = LAMP_RED;
        lamp_b_nx = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ARM;
      lamp_a     <= LAMP_RED;
      lamp_b     <= LAMP_RED;
      fault      <= 1'b0;
      fault_code <= F_NONE;
      prev_a     <= 2'b00;
      prev_b     <= 2'b00;
      ycnt_a     <= 8'd0;
      ycnt_b     <= 8'd0;
      hold_cnt   <= 16'd0;
      flash_cnt  <= 16'd0;
    end else begin
      state      <= state_nx;
      lamp_a     <= lamp_a_nx;
      lamp_b     <= lamp_b_nx;
      fault      <= fault_nx;
      fault_code <= fault_code_nx;
      prev_a     <= prev_a_nx;
      prev_b     <= prev_b_nx;
      ycnt_a     <= ycnt_a_nx;
      ycnt_b     <= ycnt_b_nx;
      hold_cnt   <= hold_cnt_nx;
      flash_cnt  <= flash_cnt_nx;
    end
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: directed scenarios plus random traffic
// compared against a behavioural model of the monitor rules.
module tb_traffic_lamp_monitor;

  localparam int unsigned MY = 2;
  localparam int unsigned FH = 4;
  localparam int unsigned MH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] La, Lb;
  logic       fault_clr;
  logic [2:0] lamp_a, lamp_b, fault_code;
  logic       fault;

  int checks = 0;
  int failures = 0;

  traffic_lamp_monitor #(.MIN_YELLOW(MY), .FLASH_HALF(FH), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .La(La), .Lb(Lb), .fault_clr(fault_clr),
    .lamp_a(lamp_a), .lamp_b(lamp_b), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = arming, 1 = running, 2 = faulted
  int         m_mode;
  logic [2:0] e_la, e_lb;
  logic       e_fault;
  int         e_code;
  int         pa, pb, run_a, run_b, same_cnt, t_flash;

  function automatic logic [2:0] lamp_of(input int code);
    return 3'(1 << code);
  endfunction

  function automatic bit legal_step(input int p, input int c);
    return (c == p) || (c == (p + 1) % 3);
  endfunction

  task automatic model_reset();
    m_mode = 0; e_la = 3'b100; e_lb = 3'b100; e_fault = 1'b0; e_code = 0;
    pa = 0; pb = 0; run_a = 0; run_b = 0; same_cnt = 0; t_flash = 0;
  endtask

  task automatic enter_fault(input int code);
    m_mode = 2; e_fault = 1'b1; e_code = code; e_la = 3'b100; e_lb = 3'b100; t_flash = 0;
  endtask

  task automatic model_step(input int a, input int b, input bit clr);
    int code;
    int nsame;
    code = 0;
    if (m_mode == 0) begin
      if (a == 3 || b == 3) code = 1;
      else if (a != 2 && b != 2) code = 2;
      if (code != 0) enter_fault(code);
      else begin
        m_mode = 1; e_la = lamp_of(a); e_lb = lamp_of(b);
        pa = a; pb = b; same_cnt = 0;
        run_a = (a == 1) ? MY : 0;
        run_b = (b == 1) ? MY : 0;
      end
    end else if (m_mode == 1) begin
      nsame = (a == pa && b == pb) ? same_cnt + 1 : 0;
      // Assign from lowest to highest priority so the strongest fault remains
      if (nsame >= MH) code = 5;
      if ((pa == 1 && a == 2 && run_a < MY) || (pb == 1 && b == 2 && run_b < MY)) code = 4;
      if (!legal_step(pa, a) || !legal_step(pb, b)) code = 3;
      if (a != 2 && b != 2) code = 2;
      if (a == 3 || b == 3) code = 1;
      pa = a; pb = b;
      if (code != 0) enter_fault(code);
      else begin
        e_la = lamp_of(a); e_lb = lamp_of(b);
        same_cnt = nsame;
        run_a = (a == 1) ? ((run_a < 255) ? run_a + 1 : 255) : 0;
        run_b = (b == 1) ? ((run_b < 255) ? run_b + 1 : 255) : 0;
      end
    end else begin
      if (clr) begin
        m_mode = 0; e_fault = 1'b0; e_code = 0; e_la = 3'b100; e_lb = 3'b100;
      end else begin
        t_flash++;
        e_la = ((t_flash / FH) % 2 == 0) ? 3'b100 : 3'b000;
        e_lb = e_la;
      end
    end
  endtask

  task automatic cycle(input logic [1:0] a, input logic [1:0] b, input logic c);
    La = a; Lb = b; fault_clr = c;
    @(posedge clk);
    model_step(int'(a), int'(b), c);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; La = 2'b00; Lb = 2'b00; fault_clr = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; La = 2'b11; Lb = 2'b11; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b100, 3'b100, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b100100_0_000);
    end
    do_reset();
  endtask

  task automatic test_normal();
    logic [3:0] seq [10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0110,
                             4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b0010};
    logic [3:0] s;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s = seq[i];
      cycle(s[3:2], s[1:0], 1'b0);
      checks++;
      if ({lamp_a, lamp_b, fault, fault_code} !== {e_la, e_lb, e_fault, 3'(e_code)} || fault !== 1'b0) begin
        failures++;
        $display("FAIL normal_cycle[%0d] got %b exp %b", i, {lamp_a, lamp_b, fault, fault_code},
                 {e_la, e_lb, e_fault, 3'(e_code)});
      end
    end
  endtask

  task automatic test_conflict_flash();
    logic [2:0] want;
    do_reset();
    cycle(2'b00, 2'b10, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b100, 3'b100, 1'b1, 3'd2}) begin
      failures++;
      $display("FAIL conflict_entry got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b100100_1_010);
    end
    for (int k = 1; k < 12; k++) begin
      want = (k < 4 || k >= 8) ? 3'b100 : 3'b000;
      // Illegal input while faulted must leave the latched code alone
      cycle((k == 5) ? 2'b11 : 2'b00, 2'b00, 1'b0);
      checks++;
      if ({lamp_a, lamp_b, fault, fault_code} !== {want, want, 1'b1, 3'd2}) begin
        failures++;
        $display("FAIL flash[%0d] got %b exp %b", k, {lamp_a, lamp_b, fault, fault_code}, {want, want, 1'b1, 3'd2});
      end
    end
  endtask

  task automatic test_seq_priority();
    do_reset();
    cycle(2'b00, 2'b10, 1'b0);
    cycle(2'b10, 2'b10, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      failures++;
      $display("FAIL seq_fault got fault=%b code=%0d exp fault=1 code=3", fault, fault_code);
    end
    do_reset();
    cycle(2'b11, 2'b00, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd1 || lamp_a !== 3'b100) begin
      failures++;
      $display("FAIL illegal_priority got fault=%b code=%0d lamp_a=%b exp 1/1/100", fault, fault_code, lamp_a);
    end
  endtask

  task automatic test_yellow_short();
    do_reset();
    cycle(2'b00, 2'b10, 1'b0);
    cycle(2'b01, 2'b10, 1'b0);
    cycle(2'b10, 2'b00, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd4) begin
      failures++;
      $display("FAIL yellow_short got fault=%b code=%0d exp fault=1 code=4", fault, fault_code);
    end
    do_reset();
    cycle(2'b00, 2'b10, 1'b0);
    cycle(2'b01, 2'b10, 1'b0);
    cycle(2'b01, 2'b10, 1'b0);
    cycle(2'b10, 2'b00, 1'b0);
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b100, 3'b001, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL yellow_ok got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b100001_0_000);
    end
  endtask

  task automatic test_watchdog_clear();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle(2'b00, 2'b10, 1'b0);
      checks++;
      if (fault_code !== ((i == 9) ? 3'd5 : 3'd0) || fault !== (i == 9)) begin
        failures++;
        $display("FAIL watchdog[%0d] got fault=%b code=%0d exp fault=%0d code=%0d",
                 i, fault, fault_code, (i == 9), (i == 9) ? 5 : 0);
      end
    end
    cycle(2'b11, 2'b11, 1'b1);
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b100, 3'b100, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL clear got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b100100_0_000);
    end
    cycle(2'b01, 2'b10, 1'b0);
    cycle(2'b10, 2'b00, 1'b0);
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b100, 3'b001, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL rearm_track got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b100001_0_000);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(2'b00, 2'b10, 1'b0);
    cycle(2'b01, 2'b01, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b100, 3'b100, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL async_reset got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b100100_0_000);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(2'b00, 2'b10, 1'b0);
    checks++;
    if ({lamp_a, lamp_b, fault, fault_code} !== {3'b001, 3'b100, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL post_reset_arm got %b exp %b", {lamp_a, lamp_b, fault, fault_code}, 10'b001100_0_000);
    end
  endtask

  function automatic int gen_code(input int cur);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return cur;
    if (r < 95) return (cur == 3) ? 0 : (cur + 1) % 3;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    int ca, cb;
    logic c;
    do_reset();
    ca = 0; cb = 2;
    for (int i = 0; i < 800; i++) begin
      if (i % 200 == 199) begin
        do_reset();
        ca = 0; cb = 2;
      end
      ca = gen_code(ca);
      cb = gen_code(cb);
      c = (m_mode == 2) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 5);
      cycle(2'(ca), 2'(cb), c);
      checks++;
      if ({lamp_a, lamp_b, fault, fault_code} !== {e_la, e_lb, e_fault, 3'(e_code)}) begin
        failures++;
        $display("FAIL random[%0d] in=%0d,%0d clr=%b got %b exp %b", i, ca, cb, c,
                 {lamp_a, lamp_b, fault, fault_code}, {e_la, e_lb, e_fault, 3'(e_code)});
      end
    end
  endtask

  initial begin
    reset = 1'b1; La = 2'b00; Lb = 2'b00; fault_clr = 1'b0;
    model_reset();
    test_reset();
    test_normal();
    test_conflict_flash();
    test_seq_priority();
    test_yellow_short();
    test_watchdog_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exp run to end got time limit");
    $fatal(1, "timeout");
  end

endmodule
